mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single core memory port between the fetch stage (instruction requester) and the execute stage (data requester). It buffers one request per requester and serialises them onto the shared port with at most one transaction outstanding. Each response is routed back to the requester that issued it. It sits between the fetch/execute stages and the memory/bus bridge.

## Interface
Parameters:
- none; all widths come from the shared types `mem_in_type` and `mem_out_type`.

Ports:
- `clk` — input, 1. Single clock.
- `rst` — input, 1. Reset: synchronous, active-high.
- `imem_in` — input, mem_in_type (70). Fetch request: `mem_valid`(1), `mem_instr`(1), `mem_addr`(32), `mem_wdata`(32), `mem_wstrb`(4).
- `imem_out` — output, mem_out_type (33). Fetch response: `mem_ready`(1), `mem_rdata`(32).
- `dmem_in` — input, mem_in_type (70). Load/store request.
- `dmem_out` — output, mem_out_type (33). Load/store response.
- `iclear` — input, 1. Fetch redirect: discard the pending or in-flight fetch.
- `mem_in` — output, mem_in_type (70). Shared port request.
- `mem_out` — input, mem_out_type (33). Shared port response.

## Operation
- Requests are single-cycle `mem_valid` pulses.
- Each requester issues at most one request before receiving its `mem_ready`. A violation overwrites that port's slot; this is not detected.
- Per-port slot holds `{valid, request}`. It is captured on a pulse that is not forwarded in the same cycle.
- FSM states:
  - IDLE → BUSY_I when the fetch request is granted.
  - IDLE → BUSY_D when the data request is granted.
  - BUSY_x → IDLE on `mem_out.mem_ready` when the other slot is empty.
  - BUSY_x → BUSY_y on `mem_out.mem_ready` when the other slot is pending (back-to-back grant).
- Grant candidates: live pulse or valid slot.
- Grant priority (macro off): data over instruction.
- Bypass: in IDLE, a live pulse is driven onto `mem_in` in the same cycle; it is not captured in the slot.
- Slot clear: a granted slot is cleared on the grant cycle.
- `mem_in` is driven as a one-cycle `mem_valid` pulse on the grant cycle only; the other fields are don't-care otherwise.
- Response routing: in BUSY_D, `dmem_out` = `mem_out`. In BUSY_I, `imem_out` = `mem_out` unless the fetch is marked dropped. The non-owner port sees `mem_ready=0`.
- `iclear` handling:
  - Clears the instruction slot.
  - If in BUSY_I, sets `drop`. The fetch response is then suppressed (`imem_out.mem_ready=0`) and `drop` clears on that response.
  - A fetch pulse in the same cycle as `iclear` is accepted; it is the redirected fetch.
- Simultaneous events:
  - Both pulses in IDLE: the winner is forwarded, the loser is captured.
  - Response plus new pulse on the same cycle: the pulse competes for the back-to-back grant.

## Timing
- Reset values: all outputs 0, state IDLE, slots invalid, `drop=0`, RR pointer = instruction-last.
- Reset mid-transaction: any late `mem_out.mem_ready` is ignored in IDLE. The memory side must be reset concurrently.
- Added latency:
  - 0 cycles when IDLE and uncontended.
  - Otherwise the request issues on the cycle the owning transaction's `mem_ready` is seen (back-to-back, no idle bubble).
- Response latency: `imem_out`/`dmem_out` are combinational from `mem_out`; no added cycles.
- `mem_out.mem_ready` in IDLE is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin grant when both candidates exist. The port not granted last wins. The pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed data-over-instruction priority. The pointer register is absent.

## Structure
- Shared package (`wires`): `mem_in_type`, `mem_out_type`, `mem_arb_reg_type`, `init_mem_arb_reg`.
- Shared package (`constants`): `mem_arb_state_type` enum {IDLE, BUSY_I, BUSY_D}.
- Sub-module `mem_arb_slot`, instantiated twice. It contains the one-entry request buffer, with capture/clear/flush inputs and a `{valid, request}` output.
- Top level uses two-process style (combinational `v`/`rin`, registered `r`).

## Test plan
- Lone fetch `0x0000_0100` in IDLE; memory ready 2 cycles later with `0xDEAD_BEEF`:
  - `mem_in.mem_valid` in the same cycle.
  - `imem_out` = {1, `0xDEAD_BEEF`} 2 cycles later.
  - `dmem_out.mem_ready` stays 0.
- Fetch `0x104` and store `0x2000`/`wstrb 0xF` in the same cycle (macro off):
  - Store granted first.
  - Fetch issued on the cycle store `mem_ready` arrives.
  - Each response goes to its own port.
- Macro on, three back-to-back contention rounds:
  - Grants alternate D, I, D; the pointer toggles each time.
- `iclear` while BUSY_I for `0x108`, then new fetch `0x200`:
  - `0x108` response is suppressed.
  - `0x200` issues on the same cycle as the `0x108` response and its response is delivered.
- `rst` asserted during BUSY_D, memory answers one cycle later:
  - All outputs 0, state IDLE, no `dmem_out.mem_ready`.
- Load pending in the slot while a fetch is in flight, with `iclear` asserted:
  - Load slot is unaffected.
  - Load issues after the fetch response.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package   : constants, wires
// Purpose   : Shared state encoding and request/response types for mem_arbiter
// Revision  : 1.0
// ============================================================================

package constants;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } mem_arb_state_type;

endpackage

package wires;

    import constants::*;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    // rr_last_d = 1 when the data port received the most recent grant
    typedef struct packed {
        mem_arb_state_type state;
        logic              drop;
        logic              rr_last_d;
    } mem_arb_reg_type;

    localparam mem_arb_reg_type init_mem_arb_reg = '{
        state:     IDLE,
        drop:      1'b0,
        rr_last_d: 1'b0
    };

endpackage

`default_nettype wire

// File: rtl/mem_arb_slot.sv
`default_nettype none
// ============================================================================
// Module    : mem_arb_slot
// Purpose   : One-entry request buffer; capture takes precedence over clear/flush
// Revision  : 1.0
// ============================================================================

module mem_arb_slot
    import wires::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_capture,
    input  logic       i_clear,
    input  logic       i_flush,
    input  mem_in_type i_req,
    output logic       o_valid,
    output mem_in_type o_req
);

    logic       r_valid;
    mem_in_type r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_req   <= i_req;
        end else if (i_clear || i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : mem_arbiter
// Purpose   : Serialises fetch and load/store requests onto one memory port.
//             Define MEM_ARB_RR_EN for round-robin grant; otherwise data wins.
// Revision  : 1.0
// ============================================================================

module mem_arbiter
    import constants::*;
    import wires::*;
(
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    input  logic        iclear,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    mem_arb_reg_type r;
    mem_arb_reg_type w_v;

    logic       w_islot_valid, w_dslot_valid;
    mem_in_type w_islot_req, w_dslot_req;
    logic       w_i_cand, w_d_cand;
    mem_in_type w_i_req, w_d_req;
    logic       w_free;
    logic       w_grant_i, w_grant_d;

    mem_arb_slot u_islot (
        .clk       (clk),
        .rst       (rst),
        .i_capture (imem_in.mem_valid & ~w_grant_i),
        .i_clear   (w_grant_i),
        .i_flush   (iclear),
        .i_req     (imem_in),
        .o_valid   (w_islot_valid),
        .o_req     (w_islot_req)
    );

    mem_arb_slot u_dslot (
        .clk       (clk),
        .rst       (rst),
        .i_capture (dmem_in.mem_valid & ~w_grant_d),
        .i_clear   (w_grant_d),
        .i_flush   (1'b0),
        .i_req     (dmem_in),
        .o_valid   (w_dslot_valid),
        .o_req     (w_dslot_req)
    );

    always_comb begin
        w_v       = r;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;

        // A buffered fetch being redirected this cycle is no longer a candidate
        w_i_cand = imem_in.mem_valid | (w_islot_valid & ~iclear);
        w_d_cand = dmem_in.mem_valid | w_dslot_valid;
        w_i_req  = imem_in.mem_valid ? imem_in : w_islot_req;
        w_d_req  = dmem_in.mem_valid ? dmem_in : w_dslot_req;
        w_free   = (r.state == IDLE) | mem_out.mem_ready;

        if (w_free) begin
            if (w_i_cand && w_d_cand) begin
`ifdef MEM_ARB_RR_EN
                w_grant_i = r.rr_last_d;
                w_grant_d = ~r.rr_last_d;
`else
                w_grant_d = 1'b1;
`endif
            end else begin
                w_grant_i = w_i_cand;
                w_grant_d = w_d_cand;
            end
        end

        if (r.state != IDLE && mem_out.mem_ready) begin
            w_v.state = IDLE;
        end

        // Response clears drop even if iclear coincides with it
        if (r.state == BUSY_I) begin
            if (iclear) begin
                w_v.drop = 1'b1;
            end
            if (mem_out.mem_ready) begin
                w_v.drop = 1'b0;
            end
        end

        if (w_grant_i) begin
            w_v.state = BUSY_I;
        end else if (w_grant_d) begin
            w_v.state = BUSY_D;
        end

`ifdef MEM_ARB_RR_EN
        if (w_grant_i || w_grant_d) begin
            w_v.rr_last_d = w_grant_d;
        end
`endif

        mem_in = '0;
        if (w_grant_i) begin
            mem_in           = w_i_req;
            mem_in.mem_valid = 1'b1;
        end else if (w_grant_d) begin
            mem_in           = w_d_req;
            mem_in.mem_valid = 1'b1;
        end

        imem_out = '0;
        dmem_out = '0;
        if (r.state == BUSY_I && !r.drop) begin
            imem_out = mem_out;
        end
        if (r.state == BUSY_D) begin
            dmem_out = mem_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= init_mem_arb_reg;
        end else begin
            r <= w_v;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_mem_arbiter
// Purpose   : Directed vector table, corner sequences and randomized traffic
//             against a transaction-level reference model for mem_arbiter
// Revision  : 1.0
// ============================================================================

module tb_mem_arbiter;

    import wires::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;
    logic        iclear;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .iclear   (iclear),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ip;
        logic [31:0] ia;
        bit          dp;
        logic [31:0] da;
        logic [3:0]  ds;
        bit          clr;
        bit          mr;
        logic [31:0] md;
        bit          ev;
        logic [31:0] ea;
        bit          ei;
        bit          eir;
        bit          edr;
    } vec_t;

    vec_t tbl[17];

    // Reference model state
    int          own;       // 0 none, 1 fetch, 2 data
    bit          drop, last_d, pi_v, pd_v;
    mem_in_type  pi_req, pd_req;
    bit          f_wait, d_wait, m_busy;
    int          m_cnt;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic mem_in_type mk_f(input logic [31:0] a);
        mem_in_type t;
        t           = '0;
        t.mem_valid = 1'b1;
        t.mem_instr = 1'b1;
        t.mem_addr  = a;
        return t;
    endfunction

    function automatic mem_in_type mk_d(input logic [31:0] a, input logic [31:0] wd,
                                        input logic [3:0] ws);
        mem_in_type t;
        t           = '0;
        t.mem_valid = 1'b1;
        t.mem_addr  = a;
        t.mem_wdata = wd;
        t.mem_wstrb = ws;
        return t;
    endfunction

    function automatic vec_t mkv(input bit ip, input logic [31:0] ia, input bit dp,
                                 input logic [31:0] da, input logic [3:0] ds, input bit clr,
                                 input bit mr, input logic [31:0] md, input bit ev,
                                 input logic [31:0] ea, input bit ei, input bit eir,
                                 input bit edr);
        vec_t t;
        t = '{ip, ia, dp, da, ds, clr, mr, md, ev, ea, ei, eir, edr};
        return t;
    endfunction

    task automatic apply(input bit ip, input mem_in_type ireq, input bit dp,
                         input mem_in_type dreq, input bit clr, input bit mr,
                         input logic [31:0] md);
        @(negedge clk);
        imem_in           = ip ? ireq : '0;
        dmem_in           = dp ? dreq : '0;
        iclear            = clr;
        mem_out.mem_ready = mr;
        mem_out.mem_rdata = mr ? md : 32'h0;
        #2;
    endtask

    task automatic expect_out(input string tag, input bit ev, input logic [31:0] ea,
                              input bit ei, input bit eir, input bit edr,
                              input logic [31:0] md);
        chk({tag, " mem_valid"}, 70'(mem_in.mem_valid), 70'(ev));
        if (ev) chk({tag, " instr/addr"}, 70'({mem_in.mem_instr, mem_in.mem_addr}), 70'({ei, ea}));
        chk({tag, " imem_ready"}, 70'(imem_out.mem_ready), 70'(eir));
        chk({tag, " dmem_ready"}, 70'(dmem_out.mem_ready), 70'(edr));
        if (eir) chk({tag, " imem_rdata"}, 70'(imem_out.mem_rdata), 70'(md));
        if (edr) chk({tag, " dmem_rdata"}, 70'(dmem_out.mem_rdata), 70'(md));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        imem_in = '0;
        dmem_in = '0;
        iclear  = 1'b0;
        mem_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        bit          mr, clr, ip, dp, eir, edr;
        logic [31:0] md;
        mem_in_type  ireq, dreq, emi;
        int          win;
        own = 0; drop = 0; last_d = 0; pi_v = 0; pd_v = 0;
        f_wait = 0; d_wait = 0; m_busy = 0; m_cnt = 0;
        pi_req = '0; pd_req = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            mr   = m_busy && (m_cnt == 0);
            md   = $urandom;
            clr  = !mr && ($urandom_range(0, 7) == 0);
            if (clr) f_wait = 0;
            ip   = !f_wait && ($urandom_range(0, 2) == 0);
            dp   = !d_wait && ($urandom_range(0, 2) == 0);
            ireq = mk_f($urandom & 32'hFFFF_FFFC);
            dreq = mk_d($urandom, $urandom, 4'($urandom));
            apply(ip, ireq, dp, dreq, clr, mr, md);

            // Responses belong to whoever owns the port; a redirected fetch gets none
            eir = (own == 1) && !drop && mr;
            edr = (own == 2) && mr;
            if (clr) begin
                pi_v = 0;
                if (own == 1) drop = 1;
            end
            if (mr) begin
                if (own == 1) drop = 0;
                own = 0;
            end
            win = 0;
            if (own == 0) begin
                if ((ip || pi_v) && (dp || pd_v)) win = RR ? (last_d ? 1 : 2) : 2;
                else if (ip || pi_v) win = 1;
                else if (dp || pd_v) win = 2;
            end
            emi = '0;
            if (win == 1) begin
                emi = ip ? ireq : pi_req; pi_v = 0; own = 1; last_d = 0;
            end else if (win == 2) begin
                emi = dp ? dreq : pd_req; pd_v = 0; own = 2; last_d = 1;
            end
            if (ip && win != 1) begin pi_v = 1; pi_req = ireq; end
            if (dp && win != 2) begin pd_v = 1; pd_req = dreq; end

            chk("rand mem_valid", 70'(mem_in.mem_valid), 70'(win != 0));
            if (win != 0) chk("rand mem_in", mem_in, emi);
            chk("rand imem_ready", 70'(imem_out.mem_ready), 70'(eir));
            chk("rand dmem_ready", 70'(dmem_out.mem_ready), 70'(edr));
            if (eir) chk("rand imem_rdata", 70'(imem_out.mem_rdata), 70'(md));
            if (edr) chk("rand dmem_rdata", 70'(dmem_out.mem_rdata), 70'(md));

            if (eir) f_wait = 0;
            if (edr) d_wait = 0;
            if (ip) f_wait = 1;
            if (dp) d_wait = 1;
            if (mr) m_busy = 0;
            else if (m_busy) m_cnt--;
            if (win != 0) begin
                m_busy = 1;
                m_cnt  = $urandom_range(0, 2);
            end
        end
    endtask

    initial begin
        tbl[0]  = mkv(1, 32'h100, 0, 0, 0, 0, 0, 0,            1, 32'h100,  1, 0, 0);
        tbl[1]  = mkv(0, 0,       0, 0, 0, 0, 0, 0,            0, 0,        0, 0, 0);
        tbl[2]  = mkv(0, 0,       0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0,        0, 1, 0);
        tbl[3]  = mkv(1, 32'h104, 1, 32'h2000, 4'hF, 0, 0, 0,  1, 32'h2000, 0, 0, 0);
        tbl[4]  = mkv(0, 0,       0, 0, 0, 0, 0, 0,            0, 0,        0, 0, 0);
        tbl[5]  = mkv(0, 0,       0, 0, 0, 0, 1, 32'h11111111, 1, 32'h104,  1, 0, 1);
        tbl[6]  = mkv(0, 0,       0, 0, 0, 0, 1, 32'h22222222, 0, 0,        0, 1, 0);
        tbl[7]  = mkv(1, 32'h108, 0, 0, 0, 0, 0, 0,            1, 32'h108,  1, 0, 0);
        tbl[8]  = mkv(1, 32'h200, 0, 0, 0, 1, 0, 0,            0, 0,        0, 0, 0);
        tbl[9]  = mkv(0, 0,       0, 0, 0, 0, 1, 32'h33333333, 1, 32'h200,  1, 0, 0);
        tbl[10] = mkv(0, 0,       0, 0, 0, 0, 1, 32'h44444444, 0, 0,        0, 1, 0);
        tbl[11] = mkv(1, 32'h300, 0, 0, 0, 0, 0, 0,            1, 32'h300,  1, 0, 0);
        tbl[12] = mkv(0, 0,       1, 32'h4000, 4'h0, 0, 0, 0,  0, 0,        0, 0, 0);
        tbl[13] = mkv(0, 0,       0, 0, 0, 1, 0, 0,            0, 0,        0, 0, 0);
        tbl[14] = mkv(0, 0,       0, 0, 0, 0, 1, 32'h55555555, 1, 32'h4000, 0, 0, 0);
        tbl[15] = mkv(0, 0,       0, 0, 0, 0, 1, 32'h66666666, 0, 0,        0, 0, 1);
        tbl[16] = mkv(0, 0,       0, 0, 0, 0, 0, 0,            0, 0,        0, 0, 0);

        do_reset();
        #2;
        chk("reset mem_in", mem_in, '0);
        chk("reset imem_out", 70'(imem_out), 70'(0));
        chk("reset dmem_out", 70'(dmem_out), 70'(0));

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].ip, mk_f(tbl[i].ia), tbl[i].dp,
                  mk_d(tbl[i].da, ~tbl[i].da, tbl[i].ds), tbl[i].clr, tbl[i].mr, tbl[i].md);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].ei,
                       tbl[i].eir, tbl[i].edr, tbl[i].md);
        end

        // Reset while a load is in flight; the late response must be ignored
        apply(0, '0, 1, mk_d(32'h5000, 32'h0, 4'h0), 0, 0, 0);
        expect_out("rst grant", 1, 32'h5000, 0, 0, 0, 0);
        apply(0, '0, 0, '0, 0, 0, 0);
        rst = 1'b1;
        apply(0, '0, 0, '0, 0, 1, 32'h77777777);
        rst = 1'b0;
        chk("rst late mem_in", mem_in, '0);
        chk("rst late imem_out", 70'(imem_out), 70'(0));
        chk("rst late dmem_out", 70'(dmem_out), 70'(0));
        apply(1, mk_f(32'h800), 0, '0, 0, 0, 0);
        expect_out("rst idle bypass", 1, 32'h800, 1, 0, 0, 0);
        apply(0, '0, 0, '0, 0, 1, 32'h88888888);
        expect_out("rst fetch resp", 0, 0, 0, 1, 0, 32'h88888888);

        // Contention rounds with back-to-back grants
        apply(1, mk_f(32'h600), 1, mk_d(32'h700, 32'h1, 4'h1), 0, 0, 0);
        expect_out("arb c0", 1, 32'h700, 0, 0, 0, 0);
        if (RR) begin
            apply(0, '0, 1, mk_d(32'h704, 32'h2, 4'h3), 0, 1, 32'hA1A1A1A1);
            expect_out("rr c1", 1, 32'h600, 1, 0, 1, 32'hA1A1A1A1);
            apply(1, mk_f(32'h604), 0, '0, 0, 1, 32'hA2A2A2A2);
            expect_out("rr c2", 1, 32'h704, 0, 1, 0, 32'hA2A2A2A2);
            apply(0, '0, 0, '0, 0, 1, 32'hA3A3A3A3);
            expect_out("rr c3", 1, 32'h604, 1, 0, 1, 32'hA3A3A3A3);
            apply(0, '0, 0, '0, 0, 1, 32'hA4A4A4A4);
            expect_out("rr c4", 0, 0, 0, 1, 0, 32'hA4A4A4A4);
        end else begin
            apply(0, '0, 1, mk_d(32'h704, 32'h2, 4'h3), 0, 1, 32'hA1A1A1A1);
            expect_out("fix c1", 1, 32'h704, 0, 0, 1, 32'hA1A1A1A1);
            apply(0, '0, 0, '0, 0, 1, 32'hA2A2A2A2);
            expect_out("fix c2", 1, 32'h600, 1, 0, 1, 32'hA2A2A2A2);
            apply(0, '0, 0, '0, 0, 1, 32'hA3A3A3A3);
            expect_out("fix c3", 0, 0, 0, 1, 0, 32'hA3A3A3A3);
        end

        do_reset();
        run_random(2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
